// File: rtl/ccff_chain_loader.sv
// Loads a bitstream into a downstream ccff configuration chain, MSB of each word first.
// Optional feature: define CCFF_READBACK_EN to add a VERIFY pass that recirculates the chain
// once and compares the XOR parity of the bits read back against the bits shifted in.
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN = 20,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  // Bit counter must hold CHAIN_LEN itself without wrapping.
  localparam int unsigned CntW  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WordW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0]  LastBit     = CntW'(CHAIN_LEN - 1);
  localparam logic [WordW-1:0] LastWordBit = WordW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StShift,
`ifdef CCFF_READBACK_EN
    StVerify,
`endif
    StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WordW-1:0]  wcnt_q, wcnt_d;

`ifdef CCFF_READBACK_EN
  logic par_shift_q, par_shift_d;
  logic par_tail_q, par_tail_d;
  logic err_q, err_d;

  assign cfg_err = err_q;
`else
  // Tail is only observed by the readback pass.
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign cfg_err     = 1'b0;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    cnt_d         = cnt_q;
    wcnt_d        = wcnt_q;
    din_ready     = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    busy          = (state_q != StIdle);
    done          = 1'b0;
`ifdef CCFF_READBACK_EN
    par_shift_d   = par_shift_q;
    par_tail_d    = par_tail_q;
    err_d         = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d = StFetch;
          cnt_d   = '0;
          wcnt_d  = '0;
          sreg_d  = '0;
`ifdef CCFF_READBACK_EN
          par_shift_d = 1'b0;
          par_tail_d  = 1'b0;
          err_d       = 1'b0;
`endif
        end
      end
      StFetch: begin
        din_ready = 1'b1;
        if (din_valid) begin
          sreg_d  = din;
          wcnt_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        ccff_shift_en = 1'b1;
        ccff_head     = sreg_q[DATA_W-1];
        sreg_d        = sreg_q << 1;
        cnt_d         = cnt_q + 1'b1;
        wcnt_d        = wcnt_q + 1'b1;
`ifdef CCFF_READBACK_EN
        par_shift_d   = par_shift_q ^ sreg_q[DATA_W-1];
`endif
        // Chain end wins over word end; leftover LSBs of the last word are dropped.
        if (cnt_q == LastBit) begin
`ifdef CCFF_READBACK_EN
          state_d = StVerify;
          cnt_d   = '0;
`else
          state_d = StFinish;
`endif
        end else if (wcnt_q == LastWordBit) begin
          state_d = StFetch;
        end
      end
`ifdef CCFF_READBACK_EN
      StVerify: begin
        // Recirculate tail into head so the loaded configuration survives the pass.
        ccff_shift_en = 1'b1;
        ccff_head     = ccff_tail;
        cnt_d         = cnt_q + 1'b1;
        par_tail_d    = par_tail_q ^ ccff_tail;
        if (cnt_q == LastBit) begin
          state_d = StFinish;
          if (par_shift_q != (par_tail_q ^ ccff_tail)) begin
            err_d = 1'b1;
          end
        end
      end
`endif
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous abort.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
`ifdef CCFF_READBACK_EN
      par_shift_q <= 1'b0;
      par_tail_q  <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
`ifdef CCFF_READBACK_EN
      par_shift_q <= par_shift_d;
      par_tail_q  <= par_tail_d;
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 20-bit and a 3-bit instance, each driving a chain model.
module tb_ccff_chain_loader;

  localparam int LenA = 20;
  localparam int LenB = 3;

  logic       prog_clk  = 1'b0;
  logic       pReset    = 1'b1;
  logic       cfg_start = 1'b0;
  logic [7:0] din       = 8'h00;
  logic       din_valid = 1'b0;
  logic       sel       = 1'b0;

  logic start_a, ready_a, head_a, sen_a, tail_a, busy_a, done_a, err_a;
  logic start_b, ready_b, head_b, sen_b, tail_b, busy_b, done_b, err_b;
  logic o_ready, o_head, o_sen, o_busy, o_done, o_err;

  logic [LenA-1:0] chain_a = '0;
  logic [LenB-1:0] chain_b = '0;
  logic [LenA-1:0] flip_a  = '0;
  int              edge_shifts = 0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] wq[$];
  bit         hq[$];
  int sc, dc, wi, done_cyc, last_sh_cyc, head_idle_bad, stall_seen, load_base;
  bit aborted;
  logic err_at_done, busy_after, done_after, err_after, err_start;
  logic [19:0] got_seq;

  always #5 prog_clk = ~prog_clk;

  assign start_a = cfg_start & ~sel;
  assign start_b = cfg_start & sel;
  assign tail_a  = chain_a[LenA-1];
  assign tail_b  = chain_b[LenB-1];
  assign o_ready = sel ? ready_b : ready_a;
  assign o_head  = sel ? head_b : head_a;
  assign o_sen   = sel ? sen_b : sen_a;
  assign o_busy  = sel ? busy_b : busy_a;
  assign o_done  = sel ? done_b : done_a;
  assign o_err   = sel ? err_b : err_a;

  ccff_chain_loader #(.CHAIN_LEN(LenA), .DATA_W(8)) dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_start(start_a), .din(din),
    .din_valid(din_valid), .din_ready(ready_a), .ccff_head(head_a), .ccff_shift_en(sen_a),
    .ccff_tail(tail_a), .busy(busy_a), .done(done_a), .cfg_err(err_a)
  );

  ccff_chain_loader #(.CHAIN_LEN(LenB), .DATA_W(8)) dut_b (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_start(start_b), .din(din),
    .din_valid(din_valid), .din_ready(ready_b), .ccff_head(head_b), .ccff_shift_en(sen_b),
    .ccff_tail(tail_b), .busy(busy_b), .done(done_b), .cfg_err(err_b)
  );

  // Downstream chains: plain shift registers clocked by prog_clk, gated by shift enable.
  always @(posedge prog_clk) begin
    if (sen_a) chain_a <= {chain_a[LenA-2:0], head_a} ^ flip_a;
    else       chain_a <= chain_a ^ flip_a;
    if (sen_b) chain_b <= {chain_b[LenB-2:0], head_b};
    if (o_sen) edge_shifts <= edge_shifts + 1;
  end

  // Reference: concatenate queued words MSB first and keep the first n bits.
  function automatic logic [19:0] model_seq(input int n);
    logic [19:0] s;
    int k;
    s = '0;
    k = 0;
    foreach (wq[i]) begin
      for (int b = 7; b >= 0; b--) begin
        if (k < n) begin
          s = {s[18:0], wq[i][b]};
          k++;
        end
      end
    end
    return s;
  endfunction

  function automatic int exp_shifts(input int n);
`ifdef CCFF_READBACK_EN
    return 2 * n;
`else
    return n;
`endif
  endfunction

  function automatic int cur_len();
    return sel ? LenB : LenA;
  endfunction

  task automatic fill_random(input int nwords);
    wq.delete();
    for (int i = 0; i < nwords; i++) wq.push_back(8'($urandom));
  endtask

  // Runs one load on the selected instance; records what the chain saw.
  task automatic run_load(input int stall_max, input int stall2, input int glitch,
                          input int abort_after, input bit flip);
    int n, cyc, stall;
    bit finished;
    n = cur_len();
    hq.delete();
    sc = 0; dc = 0; wi = 0; done_cyc = -10; last_sh_cyc = -10;
    head_idle_bad = 0; stall_seen = 0; aborted = 0;
    err_at_done = 1'b0; busy_after = 1'b1; done_after = 1'b1; err_after = 1'b0;
    load_base = edge_shifts;
    @(negedge prog_clk);
    cfg_start = 1'b1;
    @(negedge prog_clk);
    cfg_start = 1'b0;
    err_start = o_err;
    stall = int'($urandom_range(0, stall_max));
    cyc = 0;
    finished = 0;
    while (!finished && !aborted && cyc < 600) begin
      flip_a = '0;
      if (dc > 0 && cyc == done_cyc + 1) begin
        busy_after = o_busy;
        done_after = o_done;
        err_after  = o_err;
        finished   = 1;
      end else begin
        if (o_sen) begin
          hq.push_back(o_head);
          sc++;
          last_sh_cyc = cyc;
        end else if (o_head) begin
          head_idle_bad++;
        end
        if (o_done) begin
          dc++;
          done_cyc    = cyc;
          err_at_done = o_err;
        end
        if (flip && !sel && o_sen && sc == n) flip_a = 20'h00020;
        cfg_start = (glitch > 0 && (cyc == glitch || cyc == 2 * glitch));
        if (stall > 0) begin
          din_valid = 1'b0;
          if (o_ready) begin
            stall--;
            stall_seen++;
          end
        end else if (wi < wq.size()) begin
          din_valid = 1'b1;
          din = wq[wi];
          if (o_ready) begin
            wi++;
            stall = (wi == 1 && stall2 >= 0) ? stall2 : int'($urandom_range(0, stall_max));
          end
        end else begin
          din_valid = 1'b0;
        end
        if (abort_after > 0 && o_sen && sc == abort_after) begin
          @(posedge prog_clk);
          #1;
          pReset = 1'b1;
          cfg_start = 1'b0;
          aborted = 1;
        end
      end
      if (!aborted && !finished) begin
        @(negedge prog_clk);
        cyc++;
      end
    end
    cfg_start = 1'b0;
    din_valid = 1'b0;
    flip_a = '0;
    got_seq = '0;
    for (int i = 0; i < n && i < hq.size(); i++) got_seq = {got_seq[18:0], hq[i]};
    if (!finished && !aborted) begin
      vectors++;
      miscompares++;
      $display("FAIL load_timeout: cycles %0d shifts %0d dones %0d, required a done", cyc, sc, dc);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge prog_clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      vectors++;
      if ({o_busy, o_done, o_ready, o_sen, o_head, o_err} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: got %b required 000000 (inst %0d)",
                 {o_busy, o_done, o_ready, o_sen, o_head, o_err}, s);
      end
    end
    sel = 1'b0;
    @(negedge prog_clk);
    pReset = 1'b0;
    @(negedge prog_clk);
  endtask

  task automatic test_fixed_words();
    logic [19:0] want;
    want = 20'b1010_0101_0011_1100_1111;
    sel = 1'b0;
    wq.delete();
    wq.push_back(8'hA5); wq.push_back(8'h3C); wq.push_back(8'hF0);
    run_load(0, -1, 0, 0, 0);
    vectors++;
    if (got_seq !== want) begin
      miscompares++; $display("FAIL fixed_head_seq: got %05h required %05h", got_seq, want);
    end
    vectors++;
    if (sc !== exp_shifts(LenA)) begin
      miscompares++; $display("FAIL fixed_shift_count: got %0d required %0d", sc, exp_shifts(LenA));
    end
    vectors++;
    if (dc !== 1 || done_after !== 1'b0 || busy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL fixed_done_once: dones %0d done_next %b busy_next %b required 1 0 0",
               dc, done_after, busy_after);
    end
    vectors++;
    if (done_cyc !== last_sh_cyc + 1) begin
      miscompares++;
      $display("FAIL fixed_done_timing: done at %0d required %0d", done_cyc, last_sh_cyc + 1);
    end
    vectors++;
    if (chain_a !== want || head_idle_bad !== 0 || wi !== 3) begin
      miscompares++;
      $display("FAIL fixed_chain: chain %05h idle_head %0d words %0d required %05h 0 3",
               chain_a, head_idle_bad, wi, want);
    end
    vectors++;
    if (err_at_done !== 1'b0) begin
      miscompares++; $display("FAIL fixed_cfg_err: got %b required 0", err_at_done);
    end
  endtask

  task automatic test_stall();
    sel = 1'b0;
    wq.delete();
    wq.push_back(8'hA5); wq.push_back(8'h3C); wq.push_back(8'hF0);
    run_load(0, 5, 0, 0, 0);
    vectors++;
    if (got_seq !== model_seq(LenA) || sc !== exp_shifts(LenA)) begin
      miscompares++;
      $display("FAIL stall_seq: got %05h/%0d required %05h/%0d",
               got_seq, sc, model_seq(LenA), exp_shifts(LenA));
    end
    vectors++;
    if (stall_seen < 5 || dc !== 1) begin
      miscompares++;
      $display("FAIL stall_cycles: stall cycles %0d dones %0d required >=5 and 1", stall_seen, dc);
    end
  endtask

  task automatic test_busy_start();
    sel = 1'b0;
    fill_random(3);
    run_load(1, -1, 6, 0, 0);
    vectors++;
    if (got_seq !== model_seq(LenA) || sc !== exp_shifts(LenA) || dc !== 1) begin
      miscompares++;
      $display("FAIL busy_start: seq %05h shifts %0d dones %0d required %05h %0d 1",
               got_seq, sc, dc, model_seq(LenA), exp_shifts(LenA));
    end
  endtask

  task automatic test_abort();
    sel = 1'b0;
    fill_random(3);
    run_load(0, -1, 0, 9, 0);
    @(negedge prog_clk);
    vectors++;
    if ({o_busy, o_done, o_ready, o_sen, o_head, o_err} !== 6'b0 || !aborted) begin
      miscompares++;
      $display("FAIL abort_outputs: got %b aborted %0d required 000000 1",
               {o_busy, o_done, o_ready, o_sen, o_head, o_err}, aborted);
    end
    repeat (3) @(negedge prog_clk);
    vectors++;
    if (edge_shifts - load_base !== 9 || dc !== 0) begin
      miscompares++;
      $display("FAIL abort_shifts: got %0d shifts %0d dones required 9 0",
               edge_shifts - load_base, dc);
    end
    pReset = 1'b0;
    repeat (2) @(negedge prog_clk);
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++; $display("FAIL abort_idle: busy %b required 0", o_busy);
    end
    fill_random(3);
    run_load(2, -1, 0, 0, 0);
    vectors++;
    if (got_seq !== model_seq(LenA) || sc !== exp_shifts(LenA) || chain_a !== model_seq(LenA)) begin
      miscompares++;
      $display("FAIL abort_reload: seq %05h shifts %0d chain %05h required %05h %0d",
               got_seq, sc, chain_a, model_seq(LenA), exp_shifts(LenA));
    end
  endtask

  task automatic test_short_chain();
    sel = 1'b1;
    wq.delete();
    wq.push_back(8'hE0); wq.push_back(8'h55);
    run_load(0, -1, 0, 0, 0);
    vectors++;
    if (got_seq !== 20'h00007 || chain_b !== 3'b111) begin
      miscompares++;
      $display("FAIL short_seq: got %05h chain %b required 00007 111", got_seq, chain_b);
    end
    vectors++;
    if (wi !== 1 || sc !== exp_shifts(LenB)) begin
      miscompares++;
      $display("FAIL short_count: words %0d shifts %0d required 1 %0d", wi, sc, exp_shifts(LenB));
    end
    vectors++;
    if (dc !== 1 || done_cyc !== last_sh_cyc + 1) begin
      miscompares++;
      $display("FAIL short_done: dones %0d at %0d required 1 at %0d", dc, done_cyc, last_sh_cyc + 1);
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 1) == 1;
      n = cur_len();
      fill_random((n + 7) / 8 + 1);
      run_load(3, -1, 0, 0, 0);
      vectors++;
      if (got_seq !== model_seq(n) || sc !== exp_shifts(n) || wi !== (n + 7) / 8) begin
        miscompares++;
        $display("FAIL random_load[%0d]: seq %05h shifts %0d words %0d required %05h %0d %0d",
                 it, got_seq, sc, wi, model_seq(n), exp_shifts(n), (n + 7) / 8);
      end
      vectors++;
      if (dc !== 1 || done_cyc !== last_sh_cyc + 1 || busy_after !== 1'b0 ||
          head_idle_bad !== 0) begin
        miscompares++;
        $display("FAIL random_done[%0d]: dones %0d at %0d busy_next %b idle_head %0d", it, dc,
                 done_cyc, busy_after, head_idle_bad);
      end
    end
    sel = 1'b0;
  endtask

`ifdef CCFF_READBACK_EN
  task automatic test_readback();
    sel = 1'b0;
    fill_random(3);
    run_load(1, -1, 0, 0, 0);
    vectors++;
    if (err_at_done !== 1'b0 || chain_a !== model_seq(LenA) || sc !== 2 * LenA) begin
      miscompares++;
      $display("FAIL readback_good: err %b chain %05h shifts %0d required 0 %05h %0d",
               err_at_done, chain_a, sc, model_seq(LenA), 2 * LenA);
    end
    fill_random(3);
    run_load(0, -1, 0, 0, 1);
    vectors++;
    if (err_at_done !== 1'b1 || err_after !== 1'b1) begin
      miscompares++;
      $display("FAIL readback_flip: err at done %b after %b required 1 1", err_at_done, err_after);
    end
    fill_random(3);
    run_load(0, -1, 0, 0, 0);
    vectors++;
    if (err_start !== 1'b0 || err_at_done !== 1'b0) begin
      miscompares++;
      $display("FAIL readback_clear: err after start %b at done %b required 0 0",
               err_start, err_at_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed_words();
    test_stall();
    test_busy_start();
    test_abort();
    test_short_chain();
    test_random();
`ifdef CCFF_READBACK_EN
    test_readback();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
